otter_intr_timer: RTL and testbench

//  Memory-mapped machine-timer and external-interrupt aggregator on the OTTER I/O bus.

---
 rtl/otter_intr_timer.sv | 133 +++++++++++++
 tb/tb_otter_intr_timer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/otter_intr_timer.sv
// Machine timer (64-bit prescaled mtime/mtimecmp) and edge-latched external IRQ
// aggregator on the OTTER I/O bus; one-cycle registered read path.
module otter_intr_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int unsigned N_EXT     = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    input  logic [N_EXT-1:0] EXT_IRQ,
    output logic [31:0]      RD_DATA,
    output logic             RD_HIT,
    output logic             timer_int,
    output logic             m_ext_int
);

    localparam int unsigned PW = 16;

    localparam logic [2:0] REG_MTIME_LO = 3'd0;
    localparam logic [2:0] REG_MTIME_HI = 3'd1;
    localparam logic [2:0] REG_MTCMP_LO = 3'd2;
    localparam logic [2:0] REG_MTCMP_HI = 3'd3;
    localparam logic [2:0] REG_PENDING  = 3'd4;
    localparam logic [2:0] REG_ENABLE   = 3'd5;
    localparam logic [2:0] REG_PRESCALE = 3'd6;

    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic [PW-1:0]    prescale;
    logic [PW-1:0]    presc_cnt;
    logic [N_EXT-1:0] pending;
    logic [N_EXT-1:0] enable;
    logic [N_EXT-1:0] irq_meta;
    logic [N_EXT-1:0] irq_sync;
    logic [N_EXT-1:0] irq_prev;

    logic             hit;
    logic [2:0]       reg_sel;
    logic             wr_en;
    logic             tick;
    logic [N_EXT-1:0] irq_rise;
    logic [N_EXT-1:0] w1c_mask;
    logic [31:0]      rd_mux;
    logic             unused_addr_bits;

    assign hit              = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
    assign reg_sel          = IOBUS_ADDR[4:2];
    assign wr_en            = IOBUS_WR & hit;
    assign tick             = (presc_cnt == prescale);
    assign irq_rise         = irq_sync & ~irq_prev;
    assign w1c_mask         = (wr_en && reg_sel == REG_PENDING) ? IOBUS_OUT[N_EXT-1:0] : '0;
    assign unused_addr_bits = ^IOBUS_ADDR[1:0];

    // Read mux; unimplemented bits and the reserved slot read zero
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_MTIME_LO: rd_mux = mtime[31:0];
            REG_MTIME_HI: rd_mux = mtime[63:32];
            REG_MTCMP_LO: rd_mux = mtimecmp[31:0];
            REG_MTCMP_HI: rd_mux = mtimecmp[63:32];
            REG_PENDING:  rd_mux = 32'(pending);
            REG_ENABLE:   rd_mux = 32'(enable);
            REG_PRESCALE: rd_mux = 32'(prescale);
            default:      rd_mux = '0;
        endcase
    end

    // Prescaler and mtime; a software write to either mtime half suppresses that cycle's tick
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prescale  <= '0;
            presc_cnt <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
        end else begin
            if (wr_en && reg_sel == REG_PRESCALE) begin
                prescale  <= IOBUS_OUT[PW-1:0];
                presc_cnt <= '0;
            end else if (tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PW'(1);
            end

            if (wr_en && reg_sel == REG_MTIME_LO) begin
                mtime <= {mtime[63:32], IOBUS_OUT};
            end else if (wr_en && reg_sel == REG_MTIME_HI) begin
                mtime <= {IOBUS_OUT, mtime[31:0]};
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_en && reg_sel == REG_MTCMP_LO) mtimecmp[31:0]  <= IOBUS_OUT;
            if (wr_en && reg_sel == REG_MTCMP_HI) mtimecmp[63:32] <= IOBUS_OUT;
        end
    end

    // IRQ synchronizer, edge detect and pending/enable; a set edge beats a same-cycle W1C
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            irq_meta <= '0;
            irq_sync <= '0;
            irq_prev <= '0;
            pending  <= '0;
            enable   <= '0;
        end else begin
            irq_meta <= EXT_IRQ;
            irq_sync <= irq_meta;
            irq_prev <= irq_sync;
            pending  <= (pending & ~w1c_mask) | irq_rise;
            if (wr_en && reg_sel == REG_ENABLE) enable <= IOBUS_OUT[N_EXT-1:0];
        end
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RD_DATA   <= '0;
            RD_HIT    <= 1'b0;
            timer_int <= 1'b0;
            m_ext_int <= 1'b0;
        end else begin
            RD_DATA   <= hit ? rd_mux : '0;
            RD_HIT    <= hit;
            timer_int <= (mtime >= mtimecmp);
            m_ext_int <= |(pending & enable);
        end
    end

endmodule

// File: tb/tb_otter_intr_timer.sv
// Directed bench for otter_intr_timer: bus writes/reads driven on the falling edge,
// outputs sampled 1 ns after the rising edge.
module tb_otter_intr_timer;

    localparam logic [31:0] BASE     = 32'h1100_0100;
    localparam logic [31:0] A_MTLO   = BASE + 32'h00;
    localparam logic [31:0] A_MTHI   = BASE + 32'h04;
    localparam logic [31:0] A_CMPLO  = BASE + 32'h08;
    localparam logic [31:0] A_CMPHI  = BASE + 32'h0C;
    localparam logic [31:0] A_PEND   = BASE + 32'h10;
    localparam logic [31:0] A_EN     = BASE + 32'h14;
    localparam logic [31:0] A_PRESC  = BASE + 32'h18;
    localparam logic [31:0] A_RSVD   = BASE + 32'h1C;
    localparam logic [31:0] A_OUTSIDE = BASE + 32'h28;
    localparam logic [31:0] A_IDLE   = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [7:0]  EXT_IRQ;
    logic [31:0] RD_DATA;
    logic        RD_HIT;
    logic        timer_int;
    logic        m_ext_int;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rdat;
    logic        rhit;

    otter_intr_timer #(.BASE_ADDR(BASE), .N_EXT(8)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .EXT_IRQ    (EXT_IRQ),
        .RD_DATA    (RD_DATA),
        .RD_HIT     (RD_HIT),
        .timer_int  (timer_int),
        .m_ext_int  (m_ext_int)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Called at a falling edge; the store lands on the next rising edge
    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = A_IDLE;
        IOBUS_OUT  = '0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] d, output logic h);
        IOBUS_ADDR = addr;
        @(posedge CLK);
        #1;
        d = RD_DATA;
        h = RD_HIT;
        @(negedge CLK);
        IOBUS_ADDR = A_IDLE;
    endtask

    // One-cycle pulse on an IRQ line; returns at the falling edge after the first rising edge
    task automatic pulse(input int b);
        EXT_IRQ[b] = 1'b1;
        @(negedge CLK);
        EXT_IRQ[b] = 1'b0;
    endtask

    initial begin
        RST_N      = 1'b0;
        IOBUS_ADDR = A_IDLE;
        IOBUS_OUT  = '0;
        IOBUS_WR   = 1'b0;
        EXT_IRQ    = '0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_rd_data", 64'(RD_DATA), 64'd0);
        check("rst_rd_hit", 64'(RD_HIT), 64'd0);
        check("rst_timer_int", 64'(timer_int), 64'd0);
        check("rst_m_ext_int", 64'(m_ext_int), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        bus_rd(A_CMPLO, rdat, rhit);
        check("rst_cmp_lo", 64'(rdat), 64'hFFFF_FFFF);
        check("rst_cmp_lo_hit", 64'(rhit), 64'd1);
        bus_rd(A_CMPHI, rdat, rhit);
        check("rst_cmp_hi", 64'(rdat), 64'hFFFF_FFFF);
        check("rst_timer_int_after", 64'(timer_int), 64'd0);

        // Prescale 3: one tick every 4 cycles
        bus_wr(A_PRESC, 32'd3);
        bus_wr(A_MTHI, 32'd0);
        bus_wr(A_MTLO, 32'd0);
        repeat (40) @(negedge CLK);
        bus_rd(A_MTLO, rdat, rhit);
        check("presc3_mtime_lo", 64'(rdat), 64'd10);

        // LO->HI carry and full 64-bit wrap
        bus_wr(A_PRESC, 32'd0);
        bus_wr(A_MTHI, 32'd0);
        bus_wr(A_MTLO, 32'hFFFF_FFFE);
        repeat (2) @(negedge CLK);
        bus_rd(A_MTLO, rdat, rhit);
        check("carry_lo", 64'(rdat), 64'd0);
        bus_rd(A_MTHI, rdat, rhit);
        check("carry_hi", 64'(rdat), 64'd1);
        bus_wr(A_MTLO, 32'hFFFF_FFFF);
        bus_wr(A_MTHI, 32'hFFFF_FFFF);
        @(negedge CLK);
        bus_rd(A_MTLO, rdat, rhit);
        check("wrap_lo", 64'(rdat), 64'd0);
        bus_rd(A_MTHI, rdat, rhit);
        check("wrap_hi", 64'(rdat), 64'd0);

        // Compare: mtime 90 -> 100 over 10 ticks, timer_int one cycle later
        bus_wr(A_CMPHI, 32'd0);
        bus_wr(A_CMPLO, 32'd100);
        bus_wr(A_MTHI, 32'd0);
        bus_wr(A_MTLO, 32'd90);
        repeat (10) @(negedge CLK);
        check("timer_int_before", 64'(timer_int), 64'd0);
        @(negedge CLK);
        check("timer_int_rise", 64'(timer_int), 64'd1);
        bus_wr(A_CMPLO, 32'd1000);
        @(negedge CLK);
        check("timer_int_clear", 64'(timer_int), 64'd0);

        // External IRQ latency, W1C, disabled line
        bus_wr(A_EN, 32'h01);
        pulse(0);
        @(negedge CLK);
        @(negedge CLK);
        check("ext_int_3edges", 64'(m_ext_int), 64'd0);
        @(negedge CLK);
        check("ext_int_4edges", 64'(m_ext_int), 64'd1);
        bus_rd(A_PEND, rdat, rhit);
        check("pending_bit0", 64'(rdat), 64'h01);
        bus_wr(A_PEND, 32'h01);
        @(negedge CLK);
        check("ext_int_after_w1c", 64'(m_ext_int), 64'd0);
        bus_rd(A_PEND, rdat, rhit);
        check("pending_cleared", 64'(rdat), 64'h00);
        pulse(1);
        repeat (4) @(negedge CLK);
        bus_rd(A_PEND, rdat, rhit);
        check("pending_bit1_disabled", 64'(rdat), 64'h02);
        check("ext_int_disabled", 64'(m_ext_int), 64'd0);
        bus_wr(A_PEND, 32'h02);

        // Held level does not re-set pending after a clear
        EXT_IRQ[2] = 1'b1;
        repeat (4) @(negedge CLK);
        bus_rd(A_PEND, rdat, rhit);
        check("pending_level_set", 64'(rdat), 64'h04);
        bus_wr(A_PEND, 32'h04);
        repeat (4) @(negedge CLK);
        bus_rd(A_PEND, rdat, rhit);
        check("pending_level_no_reset", 64'(rdat), 64'h00);
        EXT_IRQ[2] = 1'b0;

        // Clearing ENABLE drops m_ext_int one cycle after the write
        pulse(0);
        repeat (4) @(negedge CLK);
        check("ext_int_reasserted", 64'(m_ext_int), 64'd1);
        bus_wr(A_EN, 32'h00);
        @(negedge CLK);
        check("ext_int_enable_off", 64'(m_ext_int), 64'd0);
        bus_wr(A_PEND, 32'h01);
        bus_wr(A_EN, 32'h01);

        // Set edge coincides with W1C of the same bit: set wins
        pulse(0);
        @(negedge CLK);
        bus_wr(A_PEND, 32'h01);
        bus_rd(A_PEND, rdat, rhit);
        check("set_beats_w1c", 64'(rdat), 64'h01);

        // Reserved and out-of-window writes are ignored
        bus_wr(A_RSVD, 32'hFFFF_FFFF);
        bus_wr(A_OUTSIDE, 32'h0000_0000);
        bus_rd(A_RSVD, rdat, rhit);
        check("rsvd_data", 64'(rdat), 64'd0);
        check("rsvd_hit", 64'(rhit), 64'd1);
        bus_rd(A_CMPLO | 32'h3, rdat, rhit);
        check("cmp_lo_kept", 64'(rdat), 64'd1000);
        bus_rd(A_EN, rdat, rhit);
        check("enable_kept", 64'(rdat), 64'h01);
        bus_rd(A_PRESC, rdat, rhit);
        check("presc_kept", 64'(rdat), 64'd0);
        bus_rd(A_OUTSIDE, rdat, rhit);
        check("outside_data", 64'(rdat), 64'd0);
        check("outside_hit", 64'(rhit), 64'd0);
        bus_wr(A_PRESC, 32'hABCD_1234);
        bus_rd(A_PRESC, rdat, rhit);
        check("presc_16bit", 64'(rdat), 64'h1234);

        // Asynchronous reset mid-operation
        check("ext_int_before_reset", 64'(m_ext_int), 64'd1);
        IOBUS_ADDR = A_CMPLO;
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_ext_int", 64'(m_ext_int), 64'd0);
        @(posedge CLK);
        #1;
        check("async_rst_rd_hit", 64'(RD_HIT), 64'd0);
        @(negedge CLK);
        IOBUS_ADDR = A_IDLE;
        RST_N = 1'b1;
        @(negedge CLK);
        bus_rd(A_CMPLO, rdat, rhit);
        check("post_rst_cmp_lo", 64'(rdat), 64'hFFFF_FFFF);
        bus_rd(A_EN, rdat, rhit);
        check("post_rst_enable", 64'(rdat), 64'd0);
        bus_rd(A_PEND, rdat, rhit);
        check("post_rst_pending", 64'(rdat), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
